// File: rtl/tomasula_types.sv
// Shared instruction-level types for the Tomasulo pipeline blocks.
package tomasula_types;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_LD  = 3'd4,
        OP_ST  = 3'd5,
        OP_BR  = 3'd6,
        OP_NOP = 3'd7
    } op_t;

endpackage

// File: rtl/rob_param_if.sv
// Bundle of the reorder buffer's allocate, writeback, branch, memory and commit signals.
// The master side is the surrounding pipeline; the slave side is the ROB itself.
interface rob_param_if #(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 2
);
    localparam int TAG_W = $clog2(DEPTH);

    logic                      alloc_valid;
    logic                      alloc_ready;
    tomasula_types::op_t       alloc_op;
    logic [4:0]                alloc_rd;
    logic [4:0]                alloc_st_src;
    logic [TAG_W-1:0]          alloc_tag;
    logic [NUM_WB-1:0]         wb_valid;
    logic [NUM_WB*TAG_W-1:0]   wb_tag;
    logic                      br_valid;
    logic [TAG_W-1:0]          br_tag;
    logic                      br_mispredict;
    logic                      data_mem_resp;
    logic                      data_read;
    logic                      data_write;
    logic [TAG_W-1:0]          mem_tag;
    logic [4:0]                st_commit;
    logic                      regfile_load;
    logic                      ld_commit_sel;
    logic                      ld_br;
    logic [TAG_W-1:0]          commit_tag;
    logic [4:0]                commit_rd;
    logic                      flush;
    logic                      rob_full;
    logic                      rob_empty;
    logic [TAG_W:0]            count;
    logic [DEPTH-1:0]          status_rob_valid;

    modport master (
        output alloc_valid, alloc_op, alloc_rd, alloc_st_src,
        output wb_valid, wb_tag, br_valid, br_tag, br_mispredict, data_mem_resp,
        input  alloc_ready, alloc_tag, data_read, data_write, mem_tag, st_commit,
        input  regfile_load, ld_commit_sel, ld_br, commit_tag, commit_rd, flush,
        input  rob_full, rob_empty, count, status_rob_valid
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_rd, alloc_st_src,
        input  wb_valid, wb_tag, br_valid, br_tag, br_mispredict, data_mem_resp,
        output alloc_ready, alloc_tag, data_read, data_write, mem_tag, st_commit,
        output regfile_load, ld_commit_sel, ld_br, commit_tag, commit_rd, flush,
        output rob_full, rob_empty, count, status_rob_valid
    );

endinterface

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, out-of-order writeback on NUM_WB
// channels, in-order commit through a small FSM, single-edge tag-based mispredict flush.
module rob_param #(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 2
) (
    input logic        clk,
    input logic        rst,
    rob_param_if.slave bus
);
    import tomasula_types::*;

    localparam int TAG_W = $clog2(DEPTH);
    typedef logic [TAG_W-1:0] tag_t;
    localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0] CNT_ONE  = (TAG_W+1)'(1);

    typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR} state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] alloc_q, done_q, alloc_d, done_d;
    op_t              op_q [DEPTH];
    logic [4:0]       rd_q [DEPTH];
    logic [4:0]       st_q [DEPTH];
    tag_t             head_q, tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic             regfile_load_q, ld_sel_q, ld_br_q, flush_q;
    tag_t             commit_tag_q;
    logic [4:0]       commit_rd_q;

    logic             full, mispredict_req, do_alloc, do_flush, head_elig;
    logic             retire, pulse_rf, pulse_ld, pulse_br;
    tag_t             br_pos;

    assign full           = (count_q == CNT_FULL);
    assign mispredict_req = bus.br_valid && bus.br_mispredict;
    assign do_alloc       = bus.alloc_valid && bus.alloc_ready;
    assign do_flush       = mispredict_req && alloc_q[bus.br_tag];
    assign br_pos         = bus.br_tag - head_q;
    assign head_elig      = alloc_q[head_q] && done_q[head_q];

    assign bus.alloc_ready      = !full && !mispredict_req;
    assign bus.alloc_tag        = tail_q;
    assign bus.rob_full         = full;
    assign bus.rob_empty        = (count_q == '0);
    assign bus.count            = count_q;
    assign bus.status_rob_valid = done_q;
    assign bus.data_read        = (state_q == MEM_RD);
    assign bus.data_write       = (state_q == MEM_WR);
    assign bus.mem_tag          = (state_q != IDLE) ? head_q : '0;
    assign bus.st_commit        = (state_q == MEM_WR) ? st_q[head_q] : '0;
    assign bus.regfile_load     = regfile_load_q;
    assign bus.ld_commit_sel    = ld_sel_q;
    assign bus.ld_br            = ld_br_q;
    assign bus.commit_tag       = commit_tag_q;
    assign bus.commit_rd        = commit_rd_q;
    assign bus.flush            = flush_q;

    // Commit FSM: decide whether the head retires this cycle and which pulse follows it.
    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        pulse_rf = 1'b0;
        pulse_ld = 1'b0;
        pulse_br = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_elig) begin
                    case (op_q[head_q])
                        OP_BR: begin
                            retire   = 1'b1;
                            pulse_br = 1'b1;
                        end
                        OP_LD:   state_d = MEM_RD;
                        OP_ST:   state_d = MEM_WR;
                        default: begin
                            retire   = 1'b1;
                            pulse_rf = 1'b1;
                        end
                    endcase
                end
            end
            MEM_RD: begin
                if (bus.data_mem_resp) begin
                    retire   = 1'b1;
                    pulse_rf = 1'b1;
                    pulse_ld = 1'b1;
                    state_d  = IDLE;
                end
            end
            MEM_WR: begin
                if (bus.data_mem_resp) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next alloc/done bits; later steps win so a flush discards same-cycle writebacks.
    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q;
        for (int i = 0; i < NUM_WB; i++) begin
            if (bus.wb_valid[i] && alloc_q[bus.wb_tag[i*TAG_W +: TAG_W]])
                done_d[bus.wb_tag[i*TAG_W +: TAG_W]] = 1'b1;
        end
        if (bus.br_valid && alloc_q[bus.br_tag])
            done_d[bus.br_tag] = 1'b1;
        if (do_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_q[i] && (tag_t'(tag_t'(i) - head_q) > br_pos)) begin
                    alloc_d[i] = 1'b0;
                    done_d[i]  = 1'b0;
                end
            end
        end
        if (retire) begin
            alloc_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (do_alloc) begin
            alloc_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
        end
    end

    // Next tail and occupancy; a flush rebuilds the count from the branch position.
    always_comb begin
        tail_d  = tail_q;
        count_d = count_q;
        if (do_flush) begin
            tail_d  = bus.br_tag + tag_t'(1);
            count_d = {1'b0, br_pos} + CNT_ONE;
        end else if (do_alloc) begin
            tail_d  = tail_q + tag_t'(1);
            count_d = count_q + CNT_ONE;
        end
        if (retire)
            count_d = count_d - CNT_ONE;
    end

    // Control state: pointers, occupancy, entry flags, FSM and the one-cycle commit pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            alloc_q        <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            regfile_load_q <= 1'b0;
            ld_sel_q       <= 1'b0;
            ld_br_q        <= 1'b0;
            flush_q        <= 1'b0;
            commit_tag_q   <= '0;
            commit_rd_q    <= '0;
        end else begin
            state_q        <= state_d;
            alloc_q        <= alloc_d;
            done_q         <= done_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            if (retire)
                head_q <= head_q + tag_t'(1);
            regfile_load_q <= pulse_rf;
            ld_sel_q       <= pulse_ld;
            ld_br_q        <= pulse_br;
            flush_q        <= do_flush;
            commit_tag_q   <= retire ? head_q : '0;
            commit_rd_q    <= pulse_rf ? rd_q[head_q] : '0;
        end
    end

    // Entry payload captured at allocation time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i] <= OP_NOP;
                rd_q[i] <= '0;
                st_q[i] <= '0;
            end
        end else if (do_alloc) begin
            op_q[tail_q] <= bus.alloc_op;
            rd_q[tail_q] <= bus.alloc_rd;
            st_q[tail_q] <= bus.alloc_st_src;
        end
    end

endmodule

// File: tb/tb_rob_param.sv
// Testbench for rob_param: a scoreboard queue holds the expected retire order, pushed
// at allocation and popped whenever the ROB reports a retirement.
module tb_rob_param;
    import tomasula_types::*;

    localparam int DEPTH  = 8;
    localparam int NUM_WB = 2;
    localparam int TAG_W  = 3;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [4:0]       rd;
        int               kind;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic [TAG_W-1:0] m_tail;

    exp_t             mon_e;
    int               mon_kind;
    logic [TAG_W-1:0] mon_tag;

    rob_param_if #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) bus ();

    rob_param #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int kind_of(input op_t op);
        case (op)
            OP_LD:   return 1;
            OP_BR:   return 2;
            OP_ST:   return 3;
            default: return 0;
        endcase
    endfunction

    // Retirement monitor: every commit pulse or completed store pops the scoreboard.
    always @(negedge clk) begin
        if (rst && (bus.regfile_load || bus.ld_br || (bus.data_write && bus.data_mem_resp))) begin
            if (bus.ld_br)              mon_kind = 2;
            else if (bus.data_write)    mon_kind = 3;
            else if (bus.ld_commit_sel) mon_kind = 1;
            else                        mon_kind = 0;
            mon_tag = (mon_kind == 3) ? bus.mem_tag : bus.commit_tag;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL commit_unexpected: tag %0d retired, scoreboard empty", mon_tag);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (mon_tag !== mon_e.tag) begin
                    errors++;
                    $display("[TB] FAIL commit_tag: got %0d expected %0d", mon_tag, mon_e.tag);
                end
                checks++;
                if (mon_kind != mon_e.kind) begin
                    errors++;
                    $display("[TB] FAIL commit_kind: got %0d expected %0d (tag %0d)", mon_kind, mon_e.kind, mon_e.tag);
                end
                if (mon_e.kind <= 1) begin
                    checks++;
                    if (bus.commit_rd !== mon_e.rd) begin
                        errors++;
                        $display("[TB] FAIL commit_rd: got %0d expected %0d", bus.commit_rd, mon_e.rd);
                    end
                end else if (mon_e.kind == 3) begin
                    checks++;
                    if (bus.st_commit !== mon_e.rd) begin
                        errors++;
                        $display("[TB] FAIL st_commit: got %0d expected %0d", bus.st_commit, mon_e.rd);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alloc_valid   = 1'b0;
        bus.alloc_op      = OP_ADD;
        bus.alloc_rd      = '0;
        bus.alloc_st_src  = '0;
        bus.wb_valid      = '0;
        bus.wb_tag        = '0;
        bus.br_valid      = 1'b0;
        bus.br_tag        = '0;
        bus.br_mispredict = 1'b0;
        bus.data_mem_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        exp_q.delete();
        m_tail = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic alloc_one(input op_t op, input logic [4:0] rd, input logic [4:0] st,
                             input bit expect_ok, output logic obs_ready,
                             output logic [TAG_W-1:0] obs_tag, output logic [TAG_W-1:0] exp_tag);
        exp_t e;
        bus.alloc_valid  = 1'b1;
        bus.alloc_op     = op;
        bus.alloc_rd     = rd;
        bus.alloc_st_src = st;
        @(negedge clk);
        obs_ready = bus.alloc_ready;
        obs_tag   = bus.alloc_tag;
        exp_tag   = m_tail;
        if (expect_ok) begin
            e.tag  = m_tail;
            e.kind = kind_of(op);
            e.rd   = (op == OP_ST) ? st : rd;
            exp_q.push_back(e);
            m_tail = m_tail + 1'b1;
        end
        @(posedge clk);
        #1;
        bus.alloc_valid = 1'b0;
    endtask

    task automatic wb_one(input int ch, input logic [TAG_W-1:0] tag);
        bus.wb_valid[ch]                 = 1'b1;
        bus.wb_tag[ch*TAG_W +: TAG_W]    = tag;
        step();
        bus.wb_valid = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.alloc_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_alloc_ready: got %0b expected 1", bus.alloc_ready); end
        checks++;
        if (bus.rob_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_rob_empty: got %0b expected 1", bus.rob_empty); end
        checks++;
        if (bus.count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
        checks++;
        if ({bus.rob_full, bus.flush, bus.data_read, bus.data_write, bus.regfile_load, bus.ld_br, bus.alloc_tag, bus.status_rob_valid} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: nonzero outputs full=%0b flush=%0b rd=%0b wr=%0b rl=%0b br=%0b tag=%0d st=%b expected all 0",
                     bus.rob_full, bus.flush, bus.data_read, bus.data_write, bus.regfile_load, bus.ld_br, bus.alloc_tag, bus.status_rob_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        m_tail = '0;
        step();
    endtask

    task automatic test_fill();
        logic r;
        logic [TAG_W-1:0] t, et;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_one(OP_ADD, 5'(i + 1), 5'd0, 1'b1, r, t, et);
            checks++;
            if (r !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready: entry %0d got %0b expected 1", i, r); end
            checks++;
            if (t !== et) begin errors++; $display("[TB] FAIL fill_tag: got %0d expected %0d", t, et); end
        end
        @(negedge clk);
        checks++;
        if (bus.rob_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full: got %0b expected 1", bus.rob_full); end
        checks++;
        if (bus.alloc_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready_low: got %0b expected 0", bus.alloc_ready); end
        checks++;
        if (bus.count !== 4'd8) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 8", bus.count); end
        step();
    endtask

    task automatic test_order();
        int first = -1;
        int second = -1;
        wb_one(0, 3'd1);
        wb_one(1, 3'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.regfile_load) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            step();
        end
        checks++;
        if (first != 1) begin errors++; $display("[TB] FAIL order_first_pulse: got cycle %0d expected 1", first); end
        checks++;
        if (second != 2) begin errors++; $display("[TB] FAIL order_second_pulse: got cycle %0d expected 2", second); end
        checks++;
        if (bus.count !== 4'd6) begin errors++; $display("[TB] FAIL order_count: got %0d expected 6", bus.count); end
    endtask

    task automatic test_load();
        logic r;
        logic [TAG_W-1:0] t, et;
        int  high = 0;
        bit  got = 0;
        do_reset();
        alloc_one(OP_LD, 5'd7, 5'd0, 1'b1, r, t, et);
        checks++;
        if (t !== et) begin errors++; $display("[TB] FAIL load_tag: got %0d expected %0d", t, et); end
        wb_one(1, 3'd0);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.data_read) begin
                high++;
                checks++;
                if (bus.mem_tag !== 3'd0) begin errors++; $display("[TB] FAIL load_mem_tag: got %0d expected 0", bus.mem_tag); end
                if (high == 3) begin
                    bus.data_mem_resp = 1'b1;
                    step();
                    bus.data_mem_resp = 1'b0;
                    got = 1;
                end
            end else if (high > 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL load_read_dropped: got 0 after %0d cycles expected 1", high);
                got = 1;
            end
        end
        checks++;
        if (!got) begin errors++; $display("[TB] FAIL load_timeout: data_read seen %0d cycles expected 3", high); end
        checks++;
        if (bus.data_read !== 1'b0) begin errors++; $display("[TB] FAIL load_read_release: got %0b expected 0", bus.data_read); end
        checks++;
        if ({bus.regfile_load, bus.ld_commit_sel} !== 2'b11) begin errors++; $display("[TB] FAIL load_commit_pulse: got %b expected 11", {bus.regfile_load, bus.ld_commit_sel}); end
        step();
        checks++;
        if ({bus.regfile_load, bus.ld_commit_sel} !== 2'b00) begin errors++; $display("[TB] FAIL load_pulse_end: got %b expected 00", {bus.regfile_load, bus.ld_commit_sel}); end
        checks++;
        if (bus.rob_empty !== 1'b1) begin errors++; $display("[TB] FAIL load_empty: got %0b expected 1", bus.rob_empty); end
    endtask

    task automatic test_mispredict();
        logic r;
        logic [TAG_W-1:0] t, et;
        bit  empty = 0;
        op_t ops [6] = '{OP_ADD, OP_ADD, OP_BR, OP_ADD, OP_ADD, OP_ADD};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc_one(ops[i], 5'(i + 1), 5'd0, 1'b1, r, t, et);
            checks++;
            if (t !== et) begin errors++; $display("[TB] FAIL mp_alloc_tag: got %0d expected %0d", t, et); end
        end
        bus.br_valid      = 1'b1;
        bus.br_mispredict = 1'b1;
        bus.br_tag        = 3'd2;
        bus.wb_valid      = 2'b01;
        bus.wb_tag[2:0]   = 3'd4;
        #1;
        checks++;
        if (bus.alloc_ready !== 1'b0) begin errors++; $display("[TB] FAIL mp_ready_block: got %0b expected 0", bus.alloc_ready); end
        step();
        idle_inputs();
        repeat (3) void'(exp_q.pop_back());
        m_tail = 3'd3;
        checks++;
        if (bus.flush !== 1'b1) begin errors++; $display("[TB] FAIL mp_flush: got %0b expected 1", bus.flush); end
        checks++;
        if (bus.count !== 4'd3) begin errors++; $display("[TB] FAIL mp_count: got %0d expected 3", bus.count); end
        checks++;
        if (bus.alloc_tag !== m_tail) begin errors++; $display("[TB] FAIL mp_tail: got %0d expected %0d", bus.alloc_tag, m_tail); end
        checks++;
        if (bus.status_rob_valid !== 8'b0000_0100) begin errors++; $display("[TB] FAIL mp_done_bits: got %b expected 00000100", bus.status_rob_valid); end
        step();
        checks++;
        if (bus.flush !== 1'b0) begin errors++; $display("[TB] FAIL mp_flush_pulse: got %0b expected 0", bus.flush); end
        wb_one(0, 3'd4);
        checks++;
        if (bus.status_rob_valid !== 8'b0000_0100) begin errors++; $display("[TB] FAIL mp_wb_flushed: got %b expected 00000100", bus.status_rob_valid); end
        alloc_one(OP_ADD, 5'd20, 5'd0, 1'b1, r, t, et);
        checks++;
        if (t !== et) begin errors++; $display("[TB] FAIL mp_realloc_tag: got %0d expected %0d", t, et); end
        bus.wb_valid = 2'b11;
        bus.wb_tag   = {3'd1, 3'd0};
        step();
        bus.wb_valid = '0;
        wb_one(0, 3'd3);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.rob_empty) begin
                empty = 1;
                break;
            end
        end
        step();
        checks++;
        if (!empty) begin errors++; $display("[TB] FAIL mp_drain_timeout: count %0d expected 0", bus.count); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL mp_pending: got %0d outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_full_wrap();
        logic r;
        logic [TAG_W-1:0] t, et;
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            alloc_one(OP_ADD, 5'(i + 10), 5'd0, 1'b1, r, t, et);
        wb_one(0, 3'd0);
        alloc_one(OP_ADD, 5'd25, 5'd0, 1'b0, r, t, et);
        checks++;
        if (r !== 1'b0) begin errors++; $display("[TB] FAIL wrap_ready_full: got %0b expected 0", r); end
        checks++;
        if (bus.count !== 4'd7) begin errors++; $display("[TB] FAIL wrap_count_retire: got %0d expected 7", bus.count); end
        alloc_one(OP_ADD, 5'd26, 5'd0, 1'b1, r, t, et);
        checks++;
        if (r !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ready_freed: got %0b expected 1", r); end
        checks++;
        if (t !== et) begin errors++; $display("[TB] FAIL wrap_tag: got %0d expected %0d", t, et); end
        checks++;
        if (bus.count !== 4'd8) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 8", bus.count); end
        checks++;
        if (bus.alloc_tag !== m_tail) begin errors++; $display("[TB] FAIL wrap_tail: got %0d expected %0d", bus.alloc_tag, m_tail); end
    endtask

    task automatic test_async_reset();
        logic r;
        logic [TAG_W-1:0] t, et;
        bit seen = 0;
        do_reset();
        alloc_one(OP_ST, 5'd0, 5'd9, 1'b1, r, t, et);
        wb_one(0, 3'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.data_write) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL st_write_timeout: data_write got 0 expected 1"); end
        checks++;
        if (bus.st_commit !== 5'd9) begin errors++; $display("[TB] FAIL st_src: got %0d expected 9", bus.st_commit); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.data_write, bus.data_read} !== 2'b00) begin errors++; $display("[TB] FAIL areset_mem: got %b expected 00", {bus.data_write, bus.data_read}); end
        checks++;
        if (bus.count !== 4'd0 || bus.rob_empty !== 1'b1) begin errors++; $display("[TB] FAIL areset_count: got %0d empty %0b expected 0 empty 1", bus.count, bus.rob_empty); end
        checks++;
        if (bus.status_rob_valid !== 8'd0 || bus.alloc_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_state: done %b ready %0b expected 00000000 ready 1", bus.status_rob_valid, bus.alloc_ready); end
        exp_q.delete();
        m_tail = '0;
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        idle_inputs();
        m_tail = '0;
        test_reset();
        test_fill();
        test_order();
        test_load();
        test_mispredict();
        test_full_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
